// File: rtl/wb_fetch_pkg.sv
// Shared widths, fetch state encodings and the alignment helper for the
// Wishbone instruction fetch unit.
package wb_fetch_pkg;

    localparam int unsigned FETCH_ADR_WIDTH   = 48;
    localparam int unsigned FETCH_DAT_WIDTH   = 64;
    localparam int unsigned FETCH_INSTR_BYTES = 8;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_GAP   = 2'd2,
        FETCH_FAULT = 2'd3
    } fetch_state_e;

    // True when any bit below the instruction alignment is set.
    function automatic logic adr_misaligned(input logic [63:0] adr,
                                            input int unsigned instr_bytes);
        logic [63:0] mask;
        mask = 64'(instr_bytes) - 64'd1;
        return (adr & mask) != 64'd0;
    endfunction

endpackage

// File: rtl/wb_fetch_if.sv
// Wishbone read-only fetch port: the fetch unit is the master, the
// interconnect (ROM/RAM/peripherals) answers on the slave side.
interface wb_fetch_if
    import wb_fetch_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = FETCH_ADR_WIDTH,
    parameter int unsigned DAT_WIDTH = FETCH_DAT_WIDTH
);
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;
    logic                 err;

    modport master (
        output adr, we, cyc, stb,
        input  dat, ack, err
    );

    modport slave (
        input  adr, we, cyc, stb,
        output dat, ack, err
    );
endinterface

// File: rtl/wb_fetch.sv
// Instruction fetch master: single Wishbone reads at the PC with a one-entry
// output buffer toward decode, PC redirects and a sticky fault on error.
module wb_fetch
    import wb_fetch_pkg::*;
#(
    parameter int unsigned          ADR_WIDTH   = FETCH_ADR_WIDTH,
    parameter int unsigned          DAT_WIDTH   = FETCH_DAT_WIDTH,
    parameter logic [ADR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned          INSTR_BYTES = FETCH_INSTR_BYTES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_fetch_if.master           fetch,
    output logic [DAT_WIDTH-1:0] instr_o,
    output logic [ADR_WIDTH-1:0] instr_pc_o,
    output logic                 instr_valid_o,
    input  logic                 instr_ready_i,
    input  logic                 redir_i,
    input  logic [ADR_WIDTH-1:0] redir_pc_i,
    output logic                 fault_o,
    output logic [ADR_WIDTH-1:0] fault_adr_o
);

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic                 r_stb;
    logic [ADR_WIDTH-1:0] r_pc;
    logic [DAT_WIDTH-1:0] r_instr;
    logic [ADR_WIDTH-1:0] r_instr_pc;
    logic                 r_valid;
    logic                 r_fault;
    logic [ADR_WIDTH-1:0] r_fault_adr;

    logic                 w_capture;
    logic                 w_fault_set;
    logic                 w_misaligned;
    logic                 w_buf_free;

    assign w_misaligned = adr_misaligned(64'(redir_pc_i), INSTR_BYTES);
    // Buffer is free if empty now or drained by decode this cycle.
    assign w_buf_free   = !r_valid || instr_ready_i;

    // Next-state and beat capture decisions; a redirect overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_fault_set = 1'b0;

        case (r_state)
            FETCH_IDLE: begin
                if (w_buf_free) begin
                    w_state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (fetch.err) begin
                    w_state_nxt = FETCH_FAULT;
                    w_fault_set = 1'b1;
                end else if (fetch.ack) begin
                    w_state_nxt = FETCH_GAP;
                    w_capture   = 1'b1;
                end
            end
            FETCH_GAP: begin
                w_state_nxt = w_buf_free ? FETCH_REQ : FETCH_IDLE;
            end
            FETCH_FAULT: begin
                w_state_nxt = FETCH_FAULT;
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase

        if (redir_i) begin
            w_capture   = 1'b0;
            w_fault_set = 1'b0;
            if (w_misaligned) begin
                w_state_nxt = FETCH_FAULT;
            end else if (r_state == FETCH_REQ) begin
                w_state_nxt = FETCH_GAP;
            end else begin
                w_state_nxt = FETCH_REQ;
            end
        end
    end

    // State register; stb is registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= FETCH_IDLE;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stb   <= (w_state_nxt == FETCH_REQ);
        end
    end

    // PC, output buffer and fault bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_adr <= '0;
        end else if (redir_i) begin
            r_pc    <= redir_pc_i;
            r_valid <= 1'b0;
            r_fault <= w_misaligned;
            if (w_misaligned) begin
                r_fault_adr <= redir_pc_i;
            end
        end else begin
            if (w_capture) begin
                r_instr    <= fetch.dat;
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
                r_pc       <= r_pc + ADR_WIDTH'(INSTR_BYTES);
            end else if (r_valid && instr_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_fault_set) begin
                r_fault     <= 1'b1;
                r_fault_adr <= r_pc;
            end
        end
    end

    assign fetch.adr     = r_pc;
    assign fetch.stb     = r_stb;
    assign fetch.cyc     = r_stb;
    assign fetch.we      = 1'b0;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign instr_valid_o = r_valid;
    assign fault_o       = r_fault;
    assign fault_adr_o   = r_fault_adr;

endmodule

// File: tb/tb_wb_fetch.sv
// Directed bench for wb_fetch: a registered Wishbone slave model answers the
// fetches while each task drives one scenario and checks cycle-exact results.
module tb_wb_fetch;

    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam logic [DW-1:0] WORD0 = 64'h0288400000100210;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready = 1'b0;
    logic          redir = 1'b0;
    logic [AW-1:0] redir_pc = '0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          valid;
    logic          fault;
    logic [AW-1:0] fault_adr;

    logic          r_resp;
    logic          err_en = 1'b0;
    logic [AW-1:0] err_adr = '0;
    logic          both_en = 1'b0;
    logic          w_resp;
    logic          w_err_hit;

    int n_checks = 0;
    int n_fail   = 0;

    wb_fetch_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

    wb_fetch #(
        .ADR_WIDTH(AW),
        .DAT_WIDTH(DW),
        .RESET_PC('0),
        .INSTR_BYTES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .fetch(bus),
        .instr_o(instr),
        .instr_pc_o(instr_pc),
        .instr_valid_o(valid),
        .instr_ready_i(ready),
        .redir_i(redir),
        .redir_pc_i(redir_pc),
        .fault_o(fault),
        .fault_adr_o(fault_adr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == '0) return WORD0;
        return {16'hC0DE, a};
    endfunction

    // Slave answers one cycle after it sees stb and holds until stb drops.
    always @(posedge clk) r_resp <= rst ? 1'b0 : bus.stb;
    assign w_resp    = bus.stb & r_resp;
    assign w_err_hit = err_en && (bus.adr == err_adr);
    assign bus.ack   = w_resp & (!w_err_hit | both_en);
    assign bus.err   = w_resp & (w_err_hit | both_en);
    assign bus.dat   = mem_word(bus.adr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({bus.stb, bus.cyc, bus.we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_bus stb/cyc/we got %b exp 000", {bus.stb, bus.cyc, bus.we});
        end
        n_checks++;
        if (bus.adr !== 48'h0) begin
            n_fail++; $display("FAIL reset_adr got %h exp 0", bus.adr);
        end
        n_checks++;
        if ({valid, instr, instr_pc} !== {1'b0, 64'h0, 48'h0}) begin
            n_fail++; $display("FAIL reset_instr got v=%b %h pc=%h exp all zero", valid, instr, instr_pc);
        end
        n_checks++;
        if ({fault, fault_adr} !== {1'b0, 48'h0}) begin
            n_fail++; $display("FAIL reset_fault got %b %h exp 0 0", fault, fault_adr);
        end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        ready = 1'b1;
        // cycle 0
        n_checks++;
        if (bus.stb !== 1'b0) begin
            n_fail++; $display("FAIL c0_stb got %b exp 0", bus.stb);
        end
        step(); // cycle 1
        n_checks++;
        if ({bus.stb, bus.cyc, bus.adr} !== {1'b1, 1'b1, 48'h0}) begin
            n_fail++; $display("FAIL c1_req got stb=%b cyc=%b adr=%h exp 1 1 0", bus.stb, bus.cyc, bus.adr);
        end
        step(); // cycle 2
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL c2_valid got %b exp 0", valid);
        end
        step(); // cycle 3
        n_checks++;
        if ({valid, instr, instr_pc} !== {1'b1, WORD0, 48'h0}) begin
            n_fail++; $display("FAIL c3_word got v=%b %h pc=%h exp 1 %h 0", valid, instr, instr_pc, WORD0);
        end
        n_checks++;
        if ({bus.stb, bus.adr} !== {1'b0, 48'h8}) begin
            n_fail++; $display("FAIL c3_gap got stb=%b adr=%h exp 0 8", bus.stb, bus.adr);
        end
        step(); // cycle 4
        n_checks++;
        if ({bus.stb, bus.adr, valid} !== {1'b1, 48'h8, 1'b0}) begin
            n_fail++; $display("FAIL c4_req got stb=%b adr=%h v=%b exp 1 8 0", bus.stb, bus.adr, valid);
        end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        step(); // cycle 5: ack for 0x8
        step(); // cycle 6: word 0x8 valid, stalled
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({bus.stb, valid, instr, instr_pc} !== {1'b0, 1'b1, mem_word(48'h8), 48'h8}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got stb=%b v=%b %h pc=%h exp 0 1 %h 8",
                         i, bus.stb, valid, instr, instr_pc, mem_word(48'h8));
            end
            step();
        end
        ready = 1'b1;
        step();
        n_checks++;
        if ({bus.stb, bus.adr, valid} !== {1'b1, 48'h10, 1'b0}) begin
            n_fail++; $display("FAIL stall_resume got stb=%b adr=%h v=%b exp 1 10 0", bus.stb, bus.adr, valid);
        end
    endtask

    task automatic test_bus_error();
        err_en  = 1'b1;
        err_adr = 48'h18;
        step(); // ack 0x10
        step();
        n_checks++;
        if ({valid, instr_pc, bus.adr} !== {1'b1, 48'h10, 48'h18}) begin
            n_fail++; $display("FAIL err_prev_word got v=%b pc=%h adr=%h exp 1 10 18", valid, instr_pc, bus.adr);
        end
        step(); // stb at 0x18
        step(); // err
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({fault, fault_adr, bus.stb, valid} !== {1'b1, 48'h18, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL err_fault[%0d] got f=%b fa=%h stb=%b v=%b exp 1 18 0 0",
                         i, fault, fault_adr, bus.stb, valid);
            end
            step();
        end
        err_en = 1'b0;
        redir = 1'b1;
        redir_pc = 48'h0;
        step();
        redir = 1'b0;
        n_checks++;
        if ({bus.stb, bus.adr, fault} !== {1'b1, 48'h0, 1'b0}) begin
            n_fail++; $display("FAIL err_redir got stb=%b adr=%h f=%b exp 1 0 0", bus.stb, bus.adr, fault);
        end
        step(); // ack
        step();
        n_checks++;
        if ({valid, instr, instr_pc} !== {1'b1, WORD0, 48'h0}) begin
            n_fail++; $display("FAIL err_refetch got v=%b %h pc=%h exp 1 %h 0", valid, instr, instr_pc, WORD0);
        end
    endtask

    task automatic test_redirect_in_req();
        logic seen;
        localparam logic [AW-1:0] TGT = 48'h800000000018;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.stb && bus.ack && bus.adr == 48'h10) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL redir_wait_ack got no ack at 10 within 20 cycles");
        end
        redir = 1'b1;
        redir_pc = TGT;
        step();
        redir = 1'b0;
        n_checks++;
        if ({valid, bus.stb, bus.adr, fault} !== {1'b0, 1'b0, TGT, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_discard got v=%b stb=%b adr=%h f=%b exp 0 0 %h 0", valid, bus.stb, bus.adr, fault, TGT);
        end
        step();
        n_checks++;
        if ({bus.stb, bus.adr} !== {1'b1, TGT}) begin
            n_fail++; $display("FAIL redir_req got stb=%b adr=%h exp 1 %h", bus.stb, bus.adr, TGT);
        end
        step();
        step();
        n_checks++;
        if ({valid, instr, instr_pc} !== {1'b1, mem_word(TGT), TGT}) begin
            n_fail++; $display("FAIL redir_word got v=%b %h pc=%h exp 1 %h %h", valid, instr, instr_pc, mem_word(TGT), TGT);
        end
    endtask

    task automatic test_misaligned();
        redir = 1'b1;
        redir_pc = 48'h1C;
        step();
        redir = 1'b0;
        n_checks++;
        if ({fault, fault_adr, valid} !== {1'b1, 48'h1C, 1'b0}) begin
            n_fail++; $display("FAIL misalign_fault got f=%b fa=%h v=%b exp 1 1c 0", fault, fault_adr, valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.stb !== 1'b0) begin
                n_fail++; $display("FAIL misalign_nostb[%0d] got %b exp 0", i, bus.stb);
            end
            step();
        end
    endtask

    task automatic test_ack_err();
        redir = 1'b1;
        redir_pc = 48'h40;
        step();
        redir = 1'b0;
        n_checks++;
        if ({bus.stb, bus.adr, fault} !== {1'b1, 48'h40, 1'b0}) begin
            n_fail++; $display("FAIL ackerr_req got stb=%b adr=%h f=%b exp 1 40 0", bus.stb, bus.adr, fault);
        end
        both_en = 1'b1;
        step(); // ack and err together
        step();
        both_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({fault, fault_adr, valid, bus.stb} !== {1'b1, 48'h40, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL ackerr_fault[%0d] got f=%b fa=%h v=%b stb=%b exp 1 40 0 0",
                         i, fault, fault_adr, valid, bus.stb);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_bus_error();
        test_redirect_in_req();
        test_misaligned();
        test_ack_err();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_fetch.md
# wb_fetch

Wishbone bus master that fetches 64-bit instruction words for the core. It issues single read cycles at a program counter and hands each word to decode over a valid/ready handshake. It accepts PC redirects from execute and halts with a fault flag on bus error or on a misaligned target. It sits between the decode stage and the system Wishbone interconnect, and is the initiating end of the same slave handshake that ROM, RAM and peripherals answer.

## Interface
Parameters:
- ADR_WIDTH, `ADR_WIDTH: byte address width.
- DAT_WIDTH, `DAT_WIDTH (64): instruction/bus data width.
- RESET_PC, 0: first fetch address after reset.
- INSTR_BYTES, 8: PC increment. The low log2(INSTR_BYTES) bits of every fetch address are zero.

Ports:
- clk_i  in  1  clock. Everything is registered on the rising edge.
- rst_i  in  1  reset. Synchronous, active-high.
- fetch_adr_o  out  ADR_WIDTH  Wishbone address.
- fetch_dat_i  in  DAT_WIDTH  Wishbone read data.
- fetch_we_o  out  1  Wishbone write enable. Constant 0.
- fetch_cyc_o  out  1  Wishbone cycle. Equal to fetch_stb_o.
- fetch_stb_o  out  1  Wishbone strobe.
- fetch_ack_i  in  1  Wishbone acknowledge.
- fetch_err_i  in  1  Wishbone error.
- instr_o  out  DAT_WIDTH  fetched word.
- instr_pc_o  out  ADR_WIDTH  address of instr_o.
- instr_valid_o  out  1  instr_o/instr_pc_o are valid.
- instr_ready_i  in  1  decode accepts the word this cycle.
- redir_i  in  1  PC redirect request. Single-cycle pulse.
- redir_pc_i  in  ADR_WIDTH  redirect target.
- fault_o  out  1  fetch halted. Sticky until a redirect.
- fault_adr_o  out  ADR_WIDTH  faulting address.

## Operation
- Slave contract: after a strobe, the slave raises ack or err and holds it until stb drops. ack/err are gated by stb at the slave. The master must therefore drop stb for at least one cycle between beats.
- States:
  - IDLE: buffer full and not being consumed. Wait here.
  - REQ: stb_o=1, adr_o=pc.
  - GAP: stb_o=0 for one cycle.
  - FAULT: stb_o=0. Wait for a redirect.
- Transitions:
  - IDLE→REQ when buffer empty or instr_ready_i=1.
  - REQ→GAP on ack. Capture fetch_dat_i into the buffer with instr_pc_o=pc, set valid, and set pc += INSTR_BYTES.
  - REQ→FAULT on err. Set fault_o=1 and fault_adr_o=pc. valid is unchanged.
  - If ack and err are both high, err wins.
  - GAP→REQ if buffer empty or instr_ready_i=1; otherwise GAP→IDLE.
- Consumption: instr_valid_o && instr_ready_i clears valid, unless a new word is captured in the same cycle. In that case valid stays 1 with the new word.
- Redirect (any state):
  - Clear valid and clear fault.
  - Set pc=redir_pc_i.
  - If in REQ: drop stb next cycle, discard any ack/err arriving this cycle, and go to GAP.
  - Otherwise go to REQ next cycle.
- Misaligned redirect: a target with nonzero low bits goes straight to FAULT with fault_adr_o=target. No bus cycle is issued.
- PC wraps modulo 2^ADR_WIDTH.

## Timing
- Reset values:
  - stb_o=0, cyc_o=0, we_o=0, adr_o=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - fault_o=0, fault_adr_o=0.
  - State=IDLE with the buffer empty.
- Reset asserted mid-cycle drops stb the next cycle, which the slave's abort semantics tolerate.
- Cycle 0 is the first cycle with rst_i=0.
  - stb_o=1 in cycle 1.
  - Slave ack in cycle 2.
  - instr_valid_o=1 and stb_o=0 in cycle 3.
  - With ready held high, the next stb_o=1 is in cycle 4.
- Sustained throughput is 1 word per 3 cycles; request-to-valid latency is 2 cycles.
- Redirect in cycle N: pc is updated at the end of N.
  - From a non-REQ state: stb_o=1 in N+1.
  - From REQ: GAP in N+1, stb_o=1 in N+2.
- instr_* hold stable while valid && !ready.

## Structure
- Shared in config.v: `ADR_WIDTH, `DAT_WIDTH.
- Shared in utils.v: the fetch state encodings (`FETCH_IDLE, `FETCH_REQ, `FETCH_GAP, `FETCH_FAULT).
- wishbone.v provides the master port signal macro (WB_MASTER_PORT_SIGNALS(fetch_)), the mirror of the slave macro.
- No sub-module. The single-entry output buffer is inline.

## Test plan
- Reset release, slave returns 0x0288400000100210 at 0x0, with ready=1: stb_o high in cycle 1; valid in cycle 3 with instr_pc_o=0x0; next adr_o=0x8.
- Decode stalls (ready=0) for 10 cycles after the first word: one further fetch, then IDLE; instr_o stable; no stb until ready rises.
- err_i on the fetch of 0x18: fault_o=1, fault_adr_o=0x18, stb_o stays 0. Redirect to 0x0 then clears fault and fetches 0x0 next cycle.
- Redirect to 0x800000000018 in the same cycle as an ack for 0x10: that data is discarded; valid=0 next cycle; next stb has adr_o=0x800000000018.
- Redirect to 0x1C: immediate fault with fault_adr_o=0x1C; no stb asserted.
- Simultaneous ack and err: treated as error; no word delivered.
